// File: rtl/hcp_frame_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : hcp_frame_dispatch
//  Description : Steers parsed HCP frames by ethertype to the decapsulation
//                port (TSMP) or the encapsulation port (ARP/PTP/NMAC report),
//                discards unknown types, truncates over-length frames and
//                keeps saturating per-class frame statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module hcp_frame_dispatch #(
    parameter logic [15:0] TSMP_ETYPE = 16'hff01,
    parameter logic [15:0] ARP_ETYPE  = 16'h0806,
    parameter logic [15:0] PTP_ETYPE  = 16'h88f7,
    parameter logic [15:0] RPT_ETYPE  = 16'h1662,
    parameter logic [11:0] MAX_LEN    = 12'd2047
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [8:0]  iv_data,
    input  logic [34:0] iv_descriptor,
    input  logic        i_data_wr,
    output logic [8:0]  ov_decap_data,
    output logic        o_decap_data_wr,
    output logic [8:0]  ov_encap_data,
    output logic [34:0] ov_encap_descriptor,
    output logic        o_encap_data_wr,
    output logic [15:0] ov_tsmp_cnt,
    output logic [15:0] ov_encap_cnt,
    output logic [15:0] ov_drop_cnt,
    output logic [15:0] ov_trunc_cnt,
    output logic [1:0]  ov_disp_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FWD_DECAP = 2'd1,
        ST_FWD_ENCAP = 2'd2,
        ST_DISCARD   = 2'd3
    } state_t;

    localparam logic [15:0] C_CNT_MAX  = 16'hffff;
    localparam logic [11:0] C_LAST_IDX = MAX_LEN - 12'd1;

    state_t      state_q, state_d;
    logic [11:0] len_q, len_d;
    logic        trunc_q, trunc_d;
    logic [8:0]  decap_data_q, decap_data_d;
    logic        decap_wr_q, decap_wr_d;
    logic [8:0]  encap_data_q, encap_data_d;
    logic        encap_wr_q, encap_wr_d;
    logic [34:0] desc_q, desc_d;
    logic [15:0] tsmp_cnt_q, encap_cnt_q, drop_cnt_q, trunc_cnt_q;

    logic        tsmp_inc, encap_inc, drop_inc, trunc_inc;
    logic        w_flag;
    logic [15:0] w_etype;
    logic        w_encap_type;
    logic        w_at_limit;
    logic [8:0]  w_fwd_byte;

    assign w_flag       = iv_data[8];
    assign w_etype      = iv_descriptor[15:0];
    assign w_encap_type = (w_etype == ARP_ETYPE) || (w_etype == PTP_ETYPE) ||
                          (w_etype == RPT_ETYPE);
    // A non-tail byte at the last allowed position becomes a forced tail.
    assign w_at_limit   = !w_flag && (len_q == C_LAST_IDX);
    assign w_fwd_byte   = {w_flag | w_at_limit, iv_data[7:0]};

    // State register plus the single-cycle registered output stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            len_q        <= 12'd0;
            trunc_q      <= 1'b0;
            decap_data_q <= 9'd0;
            decap_wr_q   <= 1'b0;
            encap_data_q <= 9'd0;
            encap_wr_q   <= 1'b0;
            desc_q       <= 35'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            trunc_q      <= trunc_d;
            decap_data_q <= decap_data_d;
            decap_wr_q   <= decap_wr_d;
            encap_data_q <= encap_data_d;
            encap_wr_q   <= encap_wr_d;
            desc_q       <= desc_d;
        end
    end

    // Next-state, steering and statistic-increment decode.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        trunc_d      = trunc_q;
        decap_data_d = 9'd0;
        decap_wr_d   = 1'b0;
        encap_data_d = 9'd0;
        encap_wr_d   = 1'b0;
        desc_d       = desc_q;
        tsmp_inc     = 1'b0;
        encap_inc    = 1'b0;
        drop_inc     = 1'b0;
        trunc_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The descriptor from the previous frame is released here,
                // one cycle after its tail appeared at the output.
                desc_d = 35'd0;
                if (i_data_wr && w_flag) begin
                    len_d   = 12'd1;
                    trunc_d = 1'b0;
                    if (w_etype == TSMP_ETYPE) begin
                        state_d      = ST_FWD_DECAP;
                        decap_wr_d   = 1'b1;
                        decap_data_d = iv_data;
                    end else if (w_encap_type) begin
                        state_d      = ST_FWD_ENCAP;
                        encap_wr_d   = 1'b1;
                        encap_data_d = iv_data;
                        desc_d       = iv_descriptor;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end

            ST_FWD_DECAP, ST_FWD_ENCAP: begin
                if (i_data_wr) begin
                    if (state_q == ST_FWD_DECAP) begin
                        decap_wr_d   = 1'b1;
                        decap_data_d = w_fwd_byte;
                    end else begin
                        encap_wr_d   = 1'b1;
                        encap_data_d = w_fwd_byte;
                    end
                    if (w_flag || w_at_limit) begin
                        tsmp_inc  = (state_q == ST_FWD_DECAP);
                        encap_inc = (state_q == ST_FWD_ENCAP);
                    end
                    if (w_flag) begin
                        state_d = ST_IDLE;
                    end else if (w_at_limit) begin
                        trunc_inc = 1'b1;
                        trunc_d   = 1'b1;
                        state_d   = ST_DISCARD;
                    end else begin
                        len_d = len_q + 12'd1;
                    end
                end
            end

            default: begin
                // Discard: covers unknown types and the tail end of a
                // truncated frame; only the former counts as a drop.
                desc_d = 35'd0;
                if (i_data_wr && w_flag) begin
                    state_d  = ST_IDLE;
                    drop_inc = !trunc_q;
                    trunc_d  = 1'b0;
                end
            end
        endcase
    end

    // Saturating per-class statistics.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tsmp_cnt_q  <= 16'd0;
            encap_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
            trunc_cnt_q <= 16'd0;
        end else begin
            if (tsmp_inc && (tsmp_cnt_q != C_CNT_MAX)) begin
                tsmp_cnt_q <= tsmp_cnt_q + 16'd1;
            end
            if (encap_inc && (encap_cnt_q != C_CNT_MAX)) begin
                encap_cnt_q <= encap_cnt_q + 16'd1;
            end
            if (drop_inc && (drop_cnt_q != C_CNT_MAX)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (trunc_inc && (trunc_cnt_q != C_CNT_MAX)) begin
                trunc_cnt_q <= trunc_cnt_q + 16'd1;
            end
        end
    end

    assign ov_decap_data       = decap_data_q;
    assign o_decap_data_wr     = decap_wr_q;
    assign ov_encap_data       = encap_data_q;
    assign o_encap_data_wr     = encap_wr_q;
    assign ov_encap_descriptor = desc_q;
    assign ov_tsmp_cnt         = tsmp_cnt_q;
    assign ov_encap_cnt        = encap_cnt_q;
    assign ov_drop_cnt         = drop_cnt_q;
    assign ov_trunc_cnt        = trunc_cnt_q;
    assign ov_disp_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_hcp_frame_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hcp_frame_dispatch
//  Description : Directed self-checking bench for hcp_frame_dispatch.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hcp_frame_dispatch;

    logic        i_clk;
    logic        i_rst;
    logic [8:0]  iv_data;
    logic [34:0] iv_descriptor;
    logic        i_data_wr;
    logic [8:0]  ov_decap_data;
    logic        o_decap_data_wr;
    logic [8:0]  ov_encap_data;
    logic [34:0] ov_encap_descriptor;
    logic        o_encap_data_wr;
    logic [15:0] ov_tsmp_cnt;
    logic [15:0] ov_encap_cnt;
    logic [15:0] ov_drop_cnt;
    logic [15:0] ov_trunc_cnt;
    logic [1:0]  ov_disp_state;

    typedef struct {
        logic [8:0]  d;
        logic [34:0] desc;
        int          cyc;
    } beat_t;

    beat_t exp_dec[$];
    beat_t exp_enc[$];
    int    n_cmp;
    int    n_err;
    int    cyc;

    hcp_frame_dispatch dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .iv_data             (iv_data),
        .iv_descriptor       (iv_descriptor),
        .i_data_wr           (i_data_wr),
        .ov_decap_data       (ov_decap_data),
        .o_decap_data_wr     (o_decap_data_wr),
        .ov_encap_data       (ov_encap_data),
        .ov_encap_descriptor (ov_encap_descriptor),
        .o_encap_data_wr     (o_encap_data_wr),
        .ov_tsmp_cnt         (ov_tsmp_cnt),
        .ov_encap_cnt        (ov_encap_cnt),
        .ov_drop_cnt         (ov_drop_cnt),
        .ov_trunc_cnt        (ov_trunc_cnt),
        .ov_disp_state       (ov_disp_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: every written beat must match the next expected beat,
    // including the cycle it was due in (1-cycle latency, gaps preserved).
    always @(negedge i_clk) begin
        beat_t b;
        if (o_decap_data_wr) begin
            if (exp_dec.size() == 0) begin
                chk("dec_unexpected", {55'd0, ov_decap_data}, 64'h1ff00);
            end else begin
                b = exp_dec.pop_front();
                chk("dec_data", {55'd0, ov_decap_data}, {55'd0, b.d});
                chk("dec_cycle", cyc, b.cyc);
            end
        end else if (ov_decap_data != 9'd0) begin
            chk("dec_idle_data", {55'd0, ov_decap_data}, 64'd0);
        end
        if (o_encap_data_wr) begin
            if (exp_enc.size() == 0) begin
                chk("enc_unexpected", {55'd0, ov_encap_data}, 64'h1ff00);
            end else begin
                b = exp_enc.pop_front();
                chk("enc_data", {55'd0, ov_encap_data}, {55'd0, b.d});
                chk("enc_desc", {29'd0, ov_encap_descriptor}, {29'd0, b.desc});
                chk("enc_cycle", cyc, b.cyc);
            end
        end else if (ov_encap_data != 9'd0) begin
            chk("enc_idle_data", {55'd0, ov_encap_data}, 64'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_data_wr = 1'b0;
            iv_data   = 9'd0;
        end
    endtask

    // Drive nsend bytes of a len-byte frame. port: 0 none, 1 decap, 2 encap.
    // trunc_at: expected forced-tail byte count (0 = none). st: expected state
    // after the head has been taken.
    task automatic send_frame(input logic [15:0] et, input logic [18:0] ts,
                              input int len, input int nsend, input int port,
                              input logic [1:0] st, input int trunc_at,
                              input int gap_at, input int gap_len,
                              input logic [7:0] seed);
        beat_t b;
        logic  fl;
        for (int k = 0; k < nsend; k++) begin
            if ((gap_len > 0) && (k == gap_at)) begin
                idle(gap_len);
            end
            @(negedge i_clk);
            if (k == 1) chk("state_after_head", {62'd0, ov_disp_state}, {62'd0, st});
            fl            = (k == 0) || (k == len - 1);
            i_data_wr     = 1'b1;
            iv_data       = {fl, seed + k[7:0]};
            iv_descriptor = {ts, et};
            if ((port != 0) && ((trunc_at == 0) || (k < trunc_at))) begin
                b.d    = {fl | ((trunc_at != 0) && (k == trunc_at - 1)), seed + k[7:0]};
                b.desc = (port == 2) ? {ts, et} : 35'd0;
                b.cyc  = cyc + 1;
                if (port == 1) exp_dec.push_back(b);
                else           exp_enc.push_back(b);
            end
        end
    endtask

    task automatic chk_cnts(input string tag, input logic [15:0] t, input logic [15:0] e,
                            input logic [15:0] d, input logic [15:0] tr);
        chk({tag, "_tsmp"},  {48'd0, ov_tsmp_cnt},  {48'd0, t});
        chk({tag, "_encap"}, {48'd0, ov_encap_cnt}, {48'd0, e});
        chk({tag, "_drop"},  {48'd0, ov_drop_cnt},  {48'd0, d});
        chk({tag, "_trunc"}, {48'd0, ov_trunc_cnt}, {48'd0, tr});
        chk({tag, "_decq"},  exp_dec.size(), 0);
        chk({tag, "_encq"},  exp_enc.size(), 0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        cyc           = 0;
        i_rst         = 1'b1;
        i_data_wr     = 1'b0;
        iv_data       = 9'd0;
        iv_descriptor = 35'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_state", {62'd0, ov_disp_state}, 64'd0);
        chk("rst_dec_wr", {63'd0, o_decap_data_wr}, 64'd0);
        chk("rst_enc_wr", {63'd0, o_encap_data_wr}, 64'd0);
        chk("rst_desc", {29'd0, ov_encap_descriptor}, 64'd0);
        chk_cnts("rst", 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Stray non-head bytes in IDLE are ignored.
        @(negedge i_clk);
        i_data_wr = 1'b1; iv_data = 9'h055; iv_descriptor = {19'h1234, 16'hff01};
        @(negedge i_clk);
        iv_data = 9'h0aa;
        idle(2);
        chk("stray_state", {62'd0, ov_disp_state}, 64'd0);

        // 1: 64B TSMP frame.
        send_frame(16'hff01, 19'h1234, 64, 64, 1, 2'd1, 0, 0, 0, 8'h10);
        idle(3);
        chk_cnts("t1", 16'd1, 16'd0, 16'd0, 16'd0);

        // 2: three 60B encap frames back-to-back.
        send_frame(16'h0806, 19'h00011, 60, 60, 2, 2'd2, 0, 0, 0, 8'h20);
        send_frame(16'h88f7, 19'h00022, 60, 60, 2, 2'd2, 0, 0, 0, 8'h40);
        send_frame(16'h1662, 19'h7ffff, 60, 60, 2, 2'd2, 0, 0, 0, 8'h60);
        idle(3);
        chk("t2_desc_cleared", {29'd0, ov_encap_descriptor}, 64'd0);
        chk_cnts("t2", 16'd1, 16'd3, 16'd0, 16'd0);

        // 3: unknown type discarded, following TSMP frame forwarded.
        send_frame(16'h0800, 19'h00033, 70, 70, 0, 2'd3, 0, 0, 0, 8'h80);
        send_frame(16'hff01, 19'h00044, 20, 20, 1, 2'd1, 0, 0, 0, 8'h90);
        idle(3);
        chk_cnts("t3", 16'd2, 16'd3, 16'd1, 16'd0);

        // 4: 3000B TSMP frame truncated at 2047 bytes.
        send_frame(16'hff01, 19'h00055, 3000, 3000, 1, 2'd1, 2047, 0, 0, 8'h00);
        idle(3);
        chk_cnts("t4", 16'd3, 16'd3, 16'd1, 16'd1);

        // Boundary: exactly MAX_LEN bytes with a natural tail is not truncated.
        send_frame(16'h0806, 19'h00066, 2047, 2047, 2, 2'd2, 0, 0, 0, 8'h33);
        idle(3);
        chk_cnts("t4b", 16'd3, 16'd4, 16'd1, 16'd1);

        // 5: 5-cycle input gap mid-frame reproduced at the output.
        send_frame(16'hff01, 19'h00077, 40, 40, 1, 2'd1, 0, 20, 5, 8'hc0);
        idle(3);
        chk_cnts("t5", 16'd4, 16'd4, 16'd1, 16'd1);

        // 6: reset during byte 30 of an encap frame.
        send_frame(16'h88f7, 19'h00088, 60, 29, 2, 2'd2, 0, 0, 0, 8'hd0);
        @(negedge i_clk);
        i_data_wr = 1'b0;
        #1 i_rst = 1'b1;
        #1;
        chk("t6_enc_wr", {63'd0, o_encap_data_wr}, 64'd0);
        chk("t6_enc_data", {55'd0, ov_encap_data}, 64'd0);
        chk("t6_desc", {29'd0, ov_encap_descriptor}, 64'd0);
        chk("t6_state", {62'd0, ov_disp_state}, 64'd0);
        chk_cnts("t6_rst", 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 29; k < 59; k++) begin
            @(negedge i_clk);
            i_data_wr = 1'b1;
            iv_data   = {1'b0, 8'hd0 + k[7:0]};
        end
        idle(3);
        chk_cnts("t6_ignored", 16'd0, 16'd0, 16'd0, 16'd0);
        send_frame(16'hff01, 19'h00099, 16, 16, 1, 2'd1, 0, 0, 0, 8'he0);
        idle(3);
        chk_cnts("t6_after", 16'd1, 16'd0, 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
